// File: rtl/prog_period_pkg.sv
// Shared constants for the programmable period generator: waveform mode
// encodings and count direction encodings.
package prog_period_pkg;

    // Waveform selection carried on the 2-bit mode field
    localparam logic [1:0] MODE_PULSE  = 2'b00;
    localparam logic [1:0] MODE_SQUARE = 2'b01;
    localparam logic [1:0] MODE_PWM    = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // Count direction
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : prog_period_pkg

// File: rtl/updown_load_counter.sv
// Up/down counter with synchronous parallel load. Terminal value is all ones
// when counting up and zero when counting down; tc is only flagged while
// enabled so a stalled counter never reports a terminal count.
module updown_load_counter
    import prog_period_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEFAULT_LOAD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_LOAD);

    logic [WIDTH-1:0] term_val;

    // Terminal value depends on the direction currently in force
    always_comb begin
        term_val = (dir == DIR_UP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        tc       = en & (cnt == term_val);
    end

    // Load has priority over counting and is honoured even when disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= RESET_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            if (dir == DIR_UP) begin
                cnt <= cnt + WIDTH'(1);
            end else begin
                cnt <= cnt - WIDTH'(1);
            end
        end
    end

endmodule : updown_load_counter

// File: rtl/prog_period_gen.sv
// Programmable period generator: a reloadable up/down counter producing a
// terminal-count strobe and one waveform (pulse, square or PWM).
// Configuration written with cfg_wr is parked in a shadow set and only
// becomes active at the next terminal count, so a running period is never
// cut short; force_load bypasses that and restarts immediately.
module prog_period_gen
    import prog_period_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEFAULT_LOAD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_wr,
    input  logic             force_load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] duty,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             out,
    output logic             pending
);

    localparam logic [WIDTH-1:0] RESET_LOAD = WIDTH'(DEFAULT_LOAD);

    // Active configuration (drives the counter and waveform right now)
    logic [WIDTH-1:0] act_l;
    logic [WIDTH-1:0] act_d;
    logic [1:0]       act_mode;
    logic             act_dir;

    // Shadow configuration (waits for the next terminal count)
    logic [WIDTH-1:0] sh_l;
    logic [WIDTH-1:0] sh_d;
    logic [1:0]       sh_mode;
    logic             sh_dir;

    logic             toggle;
    logic             cnt_load;
    logic [WIDTH-1:0] next_l;
    logic [WIDTH-1:0] elapsed;

    // Cycles elapsed since the last reload, modulo 2^WIDTH
    function automatic logic [WIDTH-1:0] elapsed_of(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] reload,
        input logic             cdir
    );
        if (cdir == DIR_DOWN) begin
            return reload - cur;
        end
        return cur - reload;
    endfunction

    // PWM level: high for the first d cycles of each period
    function automatic logic pwm_level(
        input logic [WIDTH-1:0] e,
        input logic [WIDTH-1:0] d
    );
        return (e < d);
    endfunction

    updown_load_counter #(
        .WIDTH        (WIDTH),
        .DEFAULT_LOAD (DEFAULT_LOAD)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (act_dir),
        .load     (cnt_load),
        .load_val (next_l),
        .cnt      (cnt),
        .tc       (tc)
    );

    // Choose the value the counter restarts from: forced or same-cycle
    // inputs first, then a pending shadow, otherwise the active reload
    always_comb begin
        cnt_load = force_load | tc;
        next_l   = act_l;
        if (force_load || cfg_wr) begin
            next_l = load_val;
        end else if (pending) begin
            next_l = sh_l;
        end
    end

    // Shadow capture, period-boundary transfer, force path and square toggle
    always_ff @(posedge clk) begin
        if (rst) begin
            act_l    <= RESET_LOAD;
            act_d    <= '0;
            act_mode <= MODE_PULSE;
            act_dir  <= DIR_UP;
            sh_l     <= '0;
            sh_d     <= '0;
            sh_mode  <= MODE_PULSE;
            sh_dir   <= DIR_UP;
            pending  <= 1'b0;
            toggle   <= 1'b0;
        end else if (force_load) begin
            act_l    <= load_val;
            act_d    <= duty;
            act_mode <= mode;
            act_dir  <= dir;
            pending  <= 1'b0;
            toggle   <= 1'b0;
        end else begin
            if (tc) begin
                toggle <= ~toggle;
            end
            if (tc && cfg_wr) begin
                act_l    <= load_val;
                act_d    <= duty;
                act_mode <= mode;
                act_dir  <= dir;
                pending  <= 1'b0;
            end else if (tc && pending) begin
                act_l    <= sh_l;
                act_d    <= sh_d;
                act_mode <= sh_mode;
                act_dir  <= sh_dir;
                pending  <= 1'b0;
            end else if (cfg_wr) begin
                sh_l     <= load_val;
                sh_d     <= duty;
                sh_mode  <= mode;
                sh_dir   <= dir;
                pending  <= 1'b1;
            end
        end
    end

    // Waveform select from the active mode
    always_comb begin
        elapsed = elapsed_of(cnt, act_l, act_dir);
        case (act_mode)
            MODE_PULSE:  out = tc;
            MODE_SQUARE: out = toggle;
            MODE_PWM:    out = pwm_level(elapsed, act_d);
            MODE_RSVD:   out = 1'b0;
            default:     out = 1'b0;
        endcase
    end

endmodule : prog_period_gen

// File: tb/tb_prog_period_gen.sv
// Bench for prog_period_gen: directed scenarios with hand-derived numbers
// followed by a long randomized run, all checked every cycle against a
// model that tracks elapsed time within the period rather than the counter.
module tb_prog_period_gen;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         cfg_wr;
    logic         force_load;
    logic [W-1:0] load_val;
    logic [W-1:0] duty;
    logic [1:0]   mode;
    logic         dir;
    logic [W-1:0] cnt;
    logic         tc;
    logic         out;
    logic         pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_period_gen #(
        .WIDTH        (W),
        .DEFAULT_LOAD (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_wr     (cfg_wr),
        .force_load (force_load),
        .load_val   (load_val),
        .duty       (duty),
        .mode       (mode),
        .dir        (dir),
        .cnt        (cnt),
        .tc         (tc),
        .out        (out),
        .pending    (pending)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // State: active reload L, duty D, mode, dir, elapsed E within the
    // period, square level, pending flag and shadow copy.
    int m_l, m_d, m_mode, m_dir, m_e, m_tog, m_pend;
    int s_l, s_d, s_mode, s_dir;
    bit started = 0;

    function automatic int period_of(input int l, input int d);
        return (d != 0) ? l + 1 : M - l;
    endfunction

    always @(negedge clk) begin
        int p, ecnt, etc, eout;
        p    = period_of(m_l, m_dir);
        ecnt = (m_dir != 0) ? (m_l - m_e + M) % M : (m_l + m_e) % M;
        etc  = (en === 1'b1 && m_e == p - 1) ? 1 : 0;
        case (m_mode)
            0:       eout = etc;
            1:       eout = m_tog;
            2:       eout = (m_e < m_d) ? 1 : 0;
            default: eout = 0;
        endcase
        if (started) begin
            check("cnt", int'(cnt), ecnt);
            check("tc", int'(tc), etc);
            check("out", int'(out), eout);
            check("pending", int'(pending), m_pend);
        end
        if (rst === 1'b1) begin
            m_l = 0; m_d = 0; m_mode = 0; m_dir = 0; m_e = 0;
            m_tog = 0; m_pend = 0;
            s_l = 0; s_d = 0; s_mode = 0; s_dir = 0;
            started = 1;
        end else if (started) begin
            if (force_load) begin
                m_l = int'(load_val); m_d = int'(duty);
                m_mode = int'(mode); m_dir = int'(dir);
                m_e = 0; m_tog = 0; m_pend = 0;
            end else begin
                if (etc != 0) begin
                    m_tog = 1 - m_tog;
                    m_e = 0;
                    if (cfg_wr) begin
                        m_l = int'(load_val); m_d = int'(duty);
                        m_mode = int'(mode); m_dir = int'(dir);
                        m_pend = 0;
                    end else if (m_pend != 0) begin
                        m_l = s_l; m_d = s_d; m_mode = s_mode; m_dir = s_dir;
                        m_pend = 0;
                    end
                end else begin
                    if (en) m_e = m_e + 1;
                    if (cfg_wr) begin
                        s_l = int'(load_val); s_d = int'(duty);
                        s_mode = int'(mode); s_dir = int'(dir);
                        m_pend = 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tc(output int n, input int limit);
        n = 0;
        while (tc !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        if (n >= limit) begin
            checks++;
            errors++;
            $display("FAIL wait_tc actual=timeout required=tc within %0d cycles", limit);
        end
    endtask

    task automatic do_force(input int l, input int d, input int md, input int dr);
        force_load = 1'b1;
        load_val   = W'(l);
        duty       = W'(d);
        mode       = 2'(md);
        dir        = 1'(dr);
        step();
        force_load = 1'b0;
    endtask

    initial begin
        int n, hi, first_ok;
        int duties[3]  = '{3, 0, 10};
        int highs[3]   = '{3, 0, 10};

        rst = 1'b1; en = 1'b0; cfg_wr = 1'b0; force_load = 1'b0;
        load_val = '0; duty = '0; mode = 2'b00; dir = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_cnt", int'(cnt), 0);
        check("reset_out", int'(out), 0);
        check("reset_pending", int'(pending), 0);
        en = 1'b1;

        // Up L=153 pulse: first tc after 102 cycles, then period 103
        do_force(153, 0, 0, 0);
        check("t1_cnt_after_force", int'(cnt), 153);
        wait_tc(n, 400);
        check("t1_first_tc", n, 102);
        check("t1_out_is_tc", int'(out), 1);
        step();
        wait_tc(n, 400);
        check("t1_period", n + 1, 103);

        // Down L=9 square: period 10, out starts low and toggles each tc
        do_force(9, 0, 1, 1);
        check("t2_out_start", int'(out), 0);
        wait_tc(n, 50);
        check("t2_first_tc", n, 9);
        check("t2_out_at_tc", int'(out), 0);
        step();
        check("t2_out_after_tc", int'(out), 1);
        check("t2_cnt_reload", int'(cnt), 9);
        wait_tc(n, 50);
        check("t2_period", n + 1, 10);
        step();
        check("t2_out_second", int'(out), 0);

        // Up L=246 PWM: high cycles per 10-cycle period for D=3,0,10
        for (int k = 0; k < 3; k++) begin
            do_force(246, duties[k], 2, 0);
            hi = 0;
            first_ok = 1;
            for (int i = 0; i < 10; i++) begin
                if (i < highs[k] && out !== 1'b1) first_ok = 0;
                hi += int'(out);
                step();
            end
            check("t3_pwm_high_count", hi, highs[k]);
            check("t3_pwm_leading_high", first_ok, 1);
        end

        // Shadow write mid-period: current period stays 10, next is 5
        do_force(246, 0, 0, 0);
        repeat (3) step();
        cfg_wr = 1'b1; load_val = W'(251); duty = '0; mode = 2'b00; dir = 1'b0;
        step();
        cfg_wr = 1'b0;
        check("t4_pending_set", int'(pending), 1);
        check("t4_cnt_unaffected", int'(cnt), 250);
        wait_tc(n, 50);
        check("t4_remaining", n, 5);
        check("t4_cnt_at_tc", int'(cnt), 255);
        check("t4_pending_held", int'(pending), 1);
        step();
        check("t4_cnt_new_l", int'(cnt), 251);
        check("t4_pending_clear", int'(pending), 0);
        wait_tc(n, 50);
        check("t4_new_period", n + 1, 5);

        // cfg_wr coincident with tc bypasses the shadow
        cfg_wr = 1'b1; load_val = W'(200); mode = 2'b00; dir = 1'b0;
        step();
        cfg_wr = 1'b0;
        check("t5_cnt_bypass", int'(cnt), 200);
        check("t5_pending_clear", int'(pending), 0);
        repeat (10) step();
        check("t5_cnt_before_stall", int'(cnt), 210);
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            check("t5_stall_tc", int'(tc), 0);
            check("t5_stall_cnt", int'(cnt), 210);
            step();
        end
        en = 1'b1;
        wait_tc(n, 100);
        check("t5_stretched", 10 + 7 + n, 62);

        // Reset beats force_load, clearing pending state
        do_force(100, 0, 1, 0);
        repeat (5) step();
        cfg_wr = 1'b1; load_val = W'(50);
        step();
        cfg_wr = 1'b0;
        check("t6_pending_before_rst", int'(pending), 1);
        rst = 1'b1; force_load = 1'b1; load_val = W'(77);
        step();
        rst = 1'b0; force_load = 1'b0;
        check("t6_rst_cnt", int'(cnt), 0);
        check("t6_rst_out", int'(out), 0);
        check("t6_rst_pending", int'(pending), 0);

        // Up L=255: tc on every enabled cycle
        do_force(255, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check("t6_tc_every_cycle", int'(tc), 1);
            check("t6_cnt_l255", int'(cnt), 255);
            step();
        end

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            force_load = ($urandom_range(0, 49) == 0);
            cfg_wr     = ($urandom_range(0, 11) == 0);
            en         = ($urandom_range(0, 9) != 0);
            mode       = 2'($urandom_range(0, 3));
            dir        = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       load_val = W'($urandom_range(0, M - 1));
                1:       load_val = W'($urandom_range(M - 16, M - 1));
                default: load_val = W'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 1) == 0) duty = W'($urandom_range(0, 20));
            else duty = W'($urandom_range(0, M - 1));
            step();
        end
        rst = 1'b0; force_load = 1'b0; cfg_wr = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_prog_period_gen

// File: doc/prog_period_gen.md
Name: prog_period_gen

Overview:
- Parametrised successor to the Lab 1 preset/up-counter clock divider.
- Single WIDTH-bit up/down counter with a programmable reload value.
- Generates a terminal-count strobe plus one output waveform, selectable between pulse, square (toggle) and PWM modes.
- Configuration is double-buffered and applied glitch-free at the period boundary; a force-load path restarts immediately.

Parameters:
- WIDTH, 8, counter/reload/duty width (>=2)
- DEFAULT_LOAD, 0, active reload value and counter value after reset

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; when low, counter and waveform hold
- cfg_wr  in  1  capture load_val/duty/mode/dir into shadow registers
- force_load  in  1  apply config inputs to active regs now and reload counter
- load_val  in  WIDTH  reload value L
- duty  in  WIDTH  PWM high-time D in cycles
- mode  in  2  00 pulse, 01 square, 10 PWM, 11 reserved
- dir  in  1  0 up, 1 down
- cnt  out  WIDTH  current counter value
- tc  out  1  terminal-count strobe
- out  out  1  generated waveform
- pending  out  1  shadow config waiting for next tc

Behaviour:
- Reset is synchronous and active-high on rst: cnt=DEFAULT_LOAD, active L=DEFAULT_LOAD, D=0, mode=00, dir=0; square-toggle reg=0; pending=0; shadow regs=0.
- Terminal value:
  - Up: all ones; tc = en & (cnt==all ones).
  - Down: 0; tc = en & (cnt==0).
  - tc is combinational from registers.
- Counting:
  - en & !tc: cnt+1 (up) or cnt-1 (down).
  - en & tc: cnt <= active L.
  - Period P = 2^WIDTH - L (up) or L+1 (down).
  - Up with L=all ones: P=1, tc every enabled cycle.
- Elapsed count E = cnt - L (up) or L - cnt (down), modulo 2^WIDTH; E runs 0..P-1.
- Waveform `out` by active mode:
  - Pulse: out = tc.
  - Square: registered toggle flips on each tc; out = toggle; period 2P, reset level 0.
  - PWM: out = (E < D). D=0 gives constant 0; D>=P gives constant 1.
  - Reserved (11): out = 0; counter still runs.
- en low: cnt, toggle and pending hold; tc=0; PWM/square out hold their level.
- cfg_wr, no tc in the same cycle: shadow <= inputs; pending <= 1. A later cfg_wr overwrites the shadow; last write wins.
- Reload with pending=1 and no cfg_wr: active <= shadow; pending <= 0; cnt <= new L. New mode/dir take effect from the cycle after the reload. The square toggle still flips on that tc.
- cfg_wr in the same cycle as tc: inputs bypass the shadow into active regs at that reload; pending <= 0.
- force_load: active <= inputs directly; cnt <= load_val; toggle <= 0; pending <= 0; takes effect regardless of en.
- Priority: rst > force_load > reload/cfg_wr > count.
- Changing the dir input alone has no effect until it is applied via cfg or force_load.

Decomposition:
- Package prog_period_pkg: mode constants MODE_PULSE=2'b00, MODE_SQUARE=2'b01, MODE_PWM=2'b10, MODE_RSVD=2'b11; DIR_UP=0, DIR_DOWN=1.
- Sub-module updown_load_counter (WIDTH): en, dir, load, load_val inputs; cnt and tc outputs. It is the natural successor of the lab divider counter.
- Top level holds the shadow/active regs, elapsed computation and waveform mux.

Test Plan:
1. W=8: force_load with L=153, up, pulse; en=1 -> cnt=153 next cycle; tc high 102 cycles later, then every 103 cycles; out==tc.
2. Down, L=9, square: force_load -> tc every 10 cycles; out toggles on each tc, period 20, starting low.
3. Up, L=246 (P=10), PWM: D=3 gives out high for E=0..2 and low for 7 cycles; D=0 gives out always 0; D=10 gives out always 1.
4. Running up L=246; cfg_wr L=251, pending=1 mid-period -> current period stays 10; next period is 5; pending clears at that tc.
5. cfg_wr in the same cycle as tc (L=200) -> cnt=200 the next cycle; pending stays 0. en low for 7 cycles mid-period -> cnt frozen, tc=0, period stretched by exactly 7.
6. rst asserted mid-count with force_load also high -> cnt=DEFAULT_LOAD, out=0, pending=0; rst wins. Up L=255 -> tc asserted every enabled cycle.
